// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter granting one of four masters a shared 32-bit port
// Optional grant-hold limit is built only when ARB_TIMEOUT_EN is defined.
// Ports:
//   clk        clock, rising edge
//   rst        synchronous reset, active-high
//   req_i      per-master request, held for the whole transaction
//   done_i     shared resource finished the current transaction (looked at in GRANT only)
//   grant_o    registered one-hot grant, 0000 = none
//   sel_o      registered mux select = index of the granted master, held while idle
//   busy_o     high while a grant is active
//   timeout_o  one-cycle pulse after a forced release (always 0 without ARB_TIMEOUT_EN)
module mux4_rr_arbiter #(
    parameter int TIMEOUT = 200,
    parameter int TO_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req_i,
    input  logic       done_i,
    output logic [3:0] grant_o,
    output logic [1:0] sel_o,
    output logic       busy_o,
    output logic       timeout_o
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t     state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] sel_q, sel_d, ptr_q, ptr_d, arb_ptr, win;
    logic       timeout_q, timeout_d, limit, rel, arb;
    if (TIMEOUT < 2 || TIMEOUT > 255 || (2 ** TO_W) < TIMEOUT) begin : g_bad_cfg
        $error("mux4_rr_arbiter: TIMEOUT/TO_W out of range");
    end
`ifdef ARB_TIMEOUT_EN
    logic [TO_W-1:0] cnt_q, cnt_d;
    assign limit = state_q == GRANT && !done_i && cnt_q == TO_W'(TIMEOUT - 1);
    // Staying in GRANT implies done=0, so counting there is counting undone cycles.
    assign cnt_d = (state_q == GRANT && !rel) ? cnt_q + 1'b1 : '0;
    always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
`else
    assign limit = 1'b0;
`endif
    assign rel     = state_q == GRANT && (done_i || !req_i[sel_q] || limit);
    assign arb     = state_q == IDLE || rel;
    // On release the finisher drops to lowest priority by moving ptr past it before searching.
    assign arb_ptr = rel ? sel_q + 2'd1 : ptr_q;
    always_comb begin
        win = arb_ptr;
        for (int k = 3; k >= 0; k--) win = req_i[arb_ptr + 2'(k)] ? arb_ptr + 2'(k) : win;
    end
    always_comb begin
        state_d   = arb ? (|req_i ? GRANT : IDLE) : state_q;
        grant_d   = arb ? (|req_i ? 4'b0001 << win : 4'b0000) : grant_q;
        sel_d     = (arb && |req_i) ? win : sel_q;
        ptr_d     = arb_ptr;
        timeout_d = limit;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            sel_q     <= '0;
            ptr_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            timeout_q <= timeout_d;
        end
    end
    assign grant_o   = grant_q;
    assign sel_o     = sel_q;
    assign busy_o    = state_q == GRANT;
    assign timeout_o = timeout_q;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: directed vectors with a per-cycle reference model and literal pins
module tb_mux4_rr_arbiter;
`ifdef ARB_TIMEOUT_EN
    localparam int TMO   = 4;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TMO   = 200;
    localparam bit TO_EN = 1'b0;
`endif
    logic       clk = 1'b0, rst = 1'b1, done = 1'b1;
    logic [3:0] req = 4'b1111;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy, timeout;
    int checks = 0, errors = 0;
    bit chk_en = 1'b0;
    // reference model state: who owns the port, priority pointer, held-cycle count
    bit m_busy, m_to;
    int m_owner, m_ptr, m_cnt;

    mux4_rr_arbiter #(.TIMEOUT(TMO), .TO_W(8)) dut (
        .clk(clk), .rst(rst), .req_i(req), .done_i(done),
        .grant_o(grant), .sel_o(sel), .busy_o(busy), .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        bit rel, forced;
        int w;
        if (rst) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_to = 0;
        end else begin
            forced = TO_EN && m_busy && !done && (m_cnt == TMO - 1);
            rel    = m_busy && (done || !req[m_owner] || forced);
            m_to   = forced;
            if (m_busy && !rel) m_cnt = m_cnt + 1;
            if (!m_busy || rel) begin
                if (rel) m_ptr = (m_owner + 1) % 4;
                w = -1;
                for (int k = 0; k < 4; k++)
                    if (w < 0 && req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
                if (w >= 0) begin
                    m_busy = 1; m_owner = w; m_cnt = 0;
                end else m_busy = 0;
            end
        end
    end

    always @(posedge clk) begin
        logic [3:0] eg;
        #1;
        if (chk_en) begin
            eg = m_busy ? 4'(1 << m_owner) : 4'b0000;
            checks++;
            if (grant !== eg || sel !== 2'(m_owner) || busy !== m_busy || timeout !== m_to) begin
                errors++;
                $display("FAIL model t=%0t grant=%b sel=%0d busy=%b to=%b required grant=%b sel=%0d busy=%b to=%b",
                         $time, grant, sel, busy, timeout, eg, m_owner, m_busy, m_to);
            end
            checks++;
            if (busy !== grant[sel] || (grant & (grant - 4'd1)) != 4'b0000) begin
                errors++;
                $display("FAIL invariant t=%0t grant=%b sel=%0d busy=%b", $time, grant, sel, busy);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pin(input string name, input logic [3:0] g, input logic [1:0] s, input logic b, input logic t);
        checks++;
        if (grant !== g || sel !== s || busy !== b || timeout !== t) begin
            errors++;
            $display("FAIL %s grant=%b sel=%0d busy=%b to=%b required grant=%b sel=%0d busy=%b to=%b",
                     name, grant, sel, busy, timeout, g, s, b, t);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] seq [5];
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        cyc();
        chk_en = 1'b1;
        cyc();
        pin("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst = 1'b0; req = 4'b0010; done = 1'b0;
        cyc();
        pin("first_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
        cyc(); cyc();
        pin("hold", 4'b0010, 2'd1, 1'b1, 1'b0);
        done = 1'b1; req = 4'b0000;
        cyc();
        pin("release_idle", 4'b0000, 2'd1, 1'b0, 1'b0);
        cyc();
        pin("idle_sel_hold", 4'b0000, 2'd1, 1'b0, 1'b0);
        do_reset();
        req = 4'b1111; done = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            pin($sformatf("rr_wrap_%0d", i), seq[i], 2'(i % 4), 1'b1, 1'b0);
        end
        do_reset();
        req = 4'b0101; done = 1'b0;
        cyc();
        pin("skip_a", 4'b0001, 2'd0, 1'b1, 1'b0);
        done = 1'b1;
        cyc();
        pin("skip_b", 4'b0100, 2'd2, 1'b1, 1'b0);
        rst = 1'b1;
        cyc();
        pin("rst_mid", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst = 1'b0; req = 4'b1111; done = 1'b0;
        cyc();
        pin("after_rst", 4'b0001, 2'd0, 1'b1, 1'b0);
        req = 4'b1110;
        cyc();
        pin("abort", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b1111;
        cyc(); cyc();
        pin("req_change_hold", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b0010; done = 1'b1;
        cyc();
        pin("only_req_regrant", 4'b0010, 2'd1, 1'b1, 1'b0);
        done = 1'b0; req = 4'b0000;
        cyc();
        pin("abort_idle", 4'b0000, 2'd1, 1'b0, 1'b0);
        done = 1'b1;
        cyc();
        pin("done_in_idle", 4'b0000, 2'd1, 1'b0, 1'b0);
        do_reset();
        req = 4'b0001; done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            pin($sformatf("limit_%0d", i), 4'b0001, 2'd0, 1'b1, TO_EN && (i == 4 || i == 8));
        end
        req = 4'b0000;
        cyc();
        pin("final_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
